// File: rtl/fpflt_pkg.sv
// Shared constants for the int-to-float conversion scheduler: flag bit
// positions, pipeline stage states and the default requester count.
package fpflt_pkg;

  localparam int NREQ_DEF = 4;

  localparam int FLG_V = 4;
  localparam int FLG_I = 3;
  localparam int FLG_O = 2;
  localparam int FLG_U = 1;
  localparam int FLG_X = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } stage_e;

endpackage

// File: rtl/fpflt.sv
// Combinational int32 (two's complement) to IEEE single conversion,
// round-to-nearest-even. Only inexact (X) can be raised by this operation.
module fpflt
  import fpflt_pkg::*;
(
  input  logic [31:0] x,
  input  logic        run,
  output logic [31:0] z,
  output logic [4:0]  flags,
  output logic        stall
);

  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;
  logic        guard;
  logic        rest;
  logic        rnd_up;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;

  always_comb begin
    mag = x[31] ? (~x + 32'd1) : x;
    msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    // Normalise so the leading one sits at bit 31; norm[31]=0 only for x=0.
    norm   = mag << (5'd31 - msb);
    guard  = norm[7];
    rest   = |norm[6:0];
    rnd_up = guard & (rest | norm[8]);
    mant_r = {1'b0, norm[30:8]} + {23'd0, rnd_up};
    exp_r  = 8'd127 + {3'd0, msb} + {7'd0, mant_r[23]};

    z     = 32'd0;
    flags = 5'd0;
    if (run && norm[31]) begin
      z            = {x[31], exp_r, mant_r[22:0]};
      flags[FLG_X] = guard | rest;
    end
  end

  assign stall = 1'b0;

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps; the first set request
// wins. Produces a one-hot grant and the winner index.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] winner,
  output logic           valid
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Walk from the farthest offset back to ptr so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        winner = IDW'(idx);
        valid  = 1'b1;
      end
    end
    if (valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/fpflt_sched.sv
// Shares one fpflt converter among NREQ requesters: round-robin grant into an
// operand stage, result stage with done pulse, and a sticky exception register.
module fpflt_sched
  import fpflt_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [32*NREQ-1:0]  x_in,
  output logic [NREQ-1:0]     ack,
  output logic                busy,
  output logic                done,
  output logic [IDW-1:0]      done_id,
  output logic [31:0]         z,
  output logic [4:0]          flags,
  output logic [4:0]          sticky,
  input  logic                clr_sticky
);

  logic [31:0]     x_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  winner;
  logic            any_req;

  stage_e          s1_q, s1_d;
  logic [31:0]     s1_x_q, s1_x_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            done_q, done_d;
  logic [31:0]     z_q, z_d;
  logic [4:0]      flags_q, flags_d;
  logic [4:0]      sticky_q, sticky_d;
  logic [IDW-1:0]  done_id_q, done_id_d;

  logic            fpflt_stall;
  logic [31:0]     fp_z;
  logic [4:0]      fp_flags;
  logic            advance;
  logic            take;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi] = x_in[32*gi +: 32];
  end

  rr_arb #(.N(NREQ), .IDW(IDW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner),
    .valid  (any_req)
  );

  fpflt u_fpflt (
    .x     (s1_x_q),
    .run   (s1_q == ST_VALID),
    .z     (fp_z),
    .flags (fp_flags),
    .stall (fpflt_stall)
  );

  always_comb begin
    advance   = (s1_q == ST_VALID) && !fpflt_stall;
    take      = ((s1_q == ST_EMPTY) || advance) && any_req && !rst;
    ack       = take ? grant : '0;

    s1_d      = s1_q;
    s1_x_d    = s1_x_q;
    s1_id_d   = s1_id_q;
    ptr_d     = ptr_q;
    if (take) begin
      s1_d    = ST_VALID;
      s1_x_d  = x_arr[winner];
      s1_id_d = winner;
      ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end else if (advance) begin
      s1_d    = ST_EMPTY;
    end

    done_d    = advance;
    z_d       = z_q;
    flags_d   = flags_q;
    done_id_d = done_id_q;
    if (advance) begin
      z_d       = fp_z;
      flags_d   = fp_flags;
      done_id_d = s1_id_q;
    end

    // A clear coinciding with a done keeps that result's flags.
    sticky_d = sticky_q;
    if (done_q) sticky_d = clr_sticky ? flags_q : (sticky_q | flags_q);
    else if (clr_sticky) sticky_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= ST_EMPTY;
      s1_x_q    <= '0;
      s1_id_q   <= '0;
      ptr_q     <= '0;
      done_q    <= 1'b0;
      z_q       <= '0;
      flags_q   <= '0;
      done_id_q <= '0;
      sticky_q  <= '0;
    end else begin
      s1_q      <= s1_d;
      s1_x_q    <= s1_x_d;
      s1_id_q   <= s1_id_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      z_q       <= z_d;
      flags_q   <= flags_d;
      done_id_q <= done_id_d;
      sticky_q  <= sticky_d;
    end
  end

  assign busy    = (s1_q == ST_VALID) || done_q;
  assign done    = done_q;
  assign z       = z_q;
  assign flags   = flags_q;
  assign done_id = done_id_q;
  assign sticky  = sticky_q;

endmodule

// File: tb/tb_fpflt_sched.sv
// Bench for fpflt_sched: a transaction-level model (real-arithmetic conversion,
// round-robin by search) checked every cycle, plus directed literal checks.
module tb_fpflt_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] x_in;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [31:0]       z;
  logic [4:0]        flags;
  logic [4:0]        sticky;
  logic              clr_sticky;

  int checks = 0;
  int errors = 0;
  logic mon_en  = 1'b0;
  logic stall_f = 1'b0;

  fpflt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .x_in       (x_in),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .z          (z),
    .flags      (flags),
    .sticky     (sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the numeric value: {flags, z}.
  function automatic logic [36:0] model_conv(input logic [31:0] x);
    longint v;
    longint r;
    real    m, s, fl, fr;
    int     e;
    logic [31:0] zz;
    logic [4:0]  ff;
    v = longint'($signed(x));
    if (v == 0) return 37'd0;
    m = (v < 0) ? real'(-v) : real'(v);
    e = 0;
    while (m >= 2.0 ** (e + 1)) e++;
    s  = m / (2.0 ** (e - 23));
    fl = $floor(s);
    fr = s - fl;
    r  = longint'(fl);
    if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r++;
    if (r == 64'd16777216) begin
      r = 64'd8388608;
      e++;
    end
    zz = {x[31], 8'(e + 127), 23'(r - 64'd8388608)};
    ff = {4'd0, (fr != 0.0)};
    return {ff, zz};
  endfunction

  // Transaction-level model state
  logic          m1_v = 0, m2_v = 0;
  logic [31:0]   m1_x = 0, m2_x = 0;
  int            m1_id = 0, m2_id = 0, m_ptr = 0;
  logic [4:0]    m_sticky = 0, m_last_f = 0;
  logic [31:0]   m_last_z = 0;
  int            m_last_id = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ack;
    logic            found;
    int              win;
    logic [36:0]     r;
    logic            adv;
    if (mon_en) begin
      exp_ack = '0;
      found   = 1'b0;
      win     = 0;
      if (!rst && !(stall_f && m1_v)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req[(m_ptr + k) % NREQ]) begin
            found = 1'b1;
            win   = (m_ptr + k) % NREQ;
          end
        end
      end
      if (found) exp_ack[win] = 1'b1;
      chk("mon_ack", 32'(ack), 32'(exp_ack));
      chk("mon_done", 32'(done), 32'(m2_v));
      chk("mon_busy", 32'(busy), 32'(m1_v | m2_v));
      chk("mon_sticky", 32'(sticky), 32'(m_sticky));
      if (m2_v) begin
        r = model_conv(m2_x);
        chk("mon_z", z, r[31:0]);
        chk("mon_flags", 32'(flags), 32'(r[36:32]));
        chk("mon_done_id", 32'(done_id), 32'(m2_id));
      end else begin
        chk("mon_z_hold", z, m_last_z);
        chk("mon_flags_hold", 32'(flags), 32'(m_last_f));
        chk("mon_id_hold", 32'(done_id), 32'(m_last_id));
      end
      if (rst) begin
        m1_v = 0; m2_v = 0; m_ptr = 0; m_sticky = 0;
        m_last_z = 0; m_last_f = 0; m_last_id = 0;
      end else begin
        if (m2_v) begin
          r = model_conv(m2_x);
          m_last_z  = r[31:0];
          m_last_f  = r[36:32];
          m_last_id = m2_id;
          m_sticky  = clr_sticky ? r[36:32] : (m_sticky | r[36:32]);
        end else if (clr_sticky) begin
          m_sticky = 0;
        end
        adv   = m1_v && !stall_f;
        m2_v  = adv;
        m2_x  = m1_x;
        m2_id = m1_id;
        if (found) begin
          m1_v  = 1'b1;
          m1_x  = x_in[32*win +: 32];
          m1_id = win;
          m_ptr = (win + 1) % NREQ;
        end else if (adv) begin
          m1_v = 1'b0;
        end
      end
    end
  end

  // One op from idle: ack in t, done in t+2, sticky visible in t+3.
  task automatic single(input int id, input logic [31:0] x, input logic [31:0] zexp,
                        input logic [4:0] fexp, input logic clr_at_done, input logic [4:0] stexp);
    @(posedge clk); #1;
    req = '0; req[id] = 1'b1; x_in[32*id +: 32] = x;
    @(negedge clk);
    chk("op_ack", 32'(ack), 32'(1) << id);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("op_done_t1", 32'(done), 32'd0);
    @(posedge clk); #1 clr_sticky = clr_at_done;
    @(negedge clk);
    chk("op_done_t2", 32'(done), 32'd1);
    chk("op_z", z, zexp);
    chk("op_flags", 32'(flags), 32'(fexp));
    chk("op_done_id", 32'(done_id), id);
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    chk("op_sticky", 32'(sticky), 32'(stexp));
    $display("op id=%0d x=%h z=%h flags=%h sticky=%h", id, x, z, flags, sticky);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [31:0] rr_z [4];

  initial begin
    logic [36:0] mr;
    rst = 1'b1; req = '0; x_in = '0; clr_sticky = 1'b0;
    rr_z[0] = 32'h3F800000; rr_z[1] = 32'h40000000;
    rr_z[2] = 32'h40400000; rr_z[3] = 32'h40800000;

    // Pin the reference model with hand-computed values.
    mr = model_conv(32'h00000001); chk("model_1", mr[31:0], 32'h3F800000);
    mr = model_conv(32'hFFFFFFFF); chk("model_m1", mr[31:0], 32'hBF800000);
    mr = model_conv(32'h80000000); chk("model_min", mr[31:0], 32'hCF000000);
    mr = model_conv(32'h01000001); chk("model_rne", 32'(mr), 32'h4B800000);
    chk("model_rne_x", 32'(mr[36:32]), 32'h1);
    mr = model_conv(32'h7FFFFFFF); chk("model_max", mr[31:0], 32'h4F000000);

    @(posedge clk); #1 mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);      chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);    chk("rst_z", z, 0);
    chk("rst_flags", 32'(flags), 0);  chk("rst_sticky", 32'(sticky), 0);
    chk("rst_done_id", 32'(done_id), 0);

    // Single op, sign, zero, extreme
    single(0, 32'h00000001, 32'h3F800000, 5'h00, 1'b0, 5'h00);
    single(1, 32'hFFFFFFFF, 32'hBF800000, 5'h00, 1'b0, 5'h00);
    single(2, 32'h00000000, 32'h00000000, 5'h00, 1'b0, 5'h00);
    single(3, 32'h80000000, 32'hCF000000, 5'h00, 1'b0, 5'h00);

    // Inexact and sticky
    single(0, 32'h01000001, 32'h4B800000, 5'h01, 1'b0, 5'h01);
    single(1, 32'h7FFFFFFF, 32'h4F000000, 5'h01, 1'b0, 5'h01);
    @(posedge clk); #1 clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_no_done", 32'(sticky), 0);
    single(2, 32'h01000001, 32'h4B800000, 5'h01, 1'b1, 5'h01);
    single(3, 32'h00000001, 32'h3F800000, 5'h00, 1'b1, 5'h00);

    // Round-robin from pointer 0
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      req  = (c < 8) ? 4'b1111 : 4'b0000;
      x_in = {32'd4, 32'd3, 32'd2, 32'd1};
      @(negedge clk);
      if (c < 8) chk("rr_ack", 32'(ack), 32'(1) << (c % 4));
      if (c >= 2) begin
        chk("rr_done", 32'(done), 1);
        chk("rr_done_id", 32'(done_id), (c - 2) % 4);
        chk("rr_z", z, rr_z[(c - 2) % 4]);
      end
      $display("rr cycle=%0d ack=%b done=%0b done_id=%0d z=%h", c, ack, done, done_id, z);
    end
    @(negedge clk);
    chk("rr_tail_done", 32'(done), 0);

    // Reset mid-op after building sticky
    single(0, 32'h01000001, 32'h4B800000, 5'h01, 1'b0, 5'h01);
    @(posedge clk); #1 req = 4'b0001; x_in[31:0] = 32'h01000001;
    @(negedge clk);
    chk("mid_ack", 32'(ack), 1);
    @(posedge clk); #1 req = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done_t2", 32'(done), 0);
    chk("mid_sticky", 32'(sticky), 0);
    for (int c = 3; c <= 4; c++) begin
      @(negedge clk);
      chk("mid_done_late", 32'(done), 0);
    end
    $display("reset mid-op busy=%0b sticky=%h", busy, sticky);

    // Forced stall for 3 cycles with S1 valid
    @(posedge clk); #1 req = 4'b0100; x_in[95:64] = 32'd5;
    @(negedge clk);
    chk("st_ack0", 32'(ack), 32'b0100);
    @(posedge clk); #1;
    req = 4'b0010; x_in[63:32] = 32'd7;
    force dut.fpflt_stall = 1'b1;
    stall_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st_ack_blocked", 32'(ack), 0);
      chk("st_no_done", 32'(done), 0);
      if (c < 2) @(posedge clk);
    end
    @(posedge clk); #1;
    release dut.fpflt_stall;
    stall_f = 1'b0;
    @(negedge clk);
    chk("st_ack1", 32'(ack), 32'b0010);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("st_done_a", 32'(done), 1);
    chk("st_z_a", z, 32'h40A00000);
    chk("st_id_a", 32'(done_id), 2);
    @(negedge clk);
    chk("st_done_b", 32'(done), 1);
    chk("st_z_b", z, 32'h40E00000);
    chk("st_id_b", 32'(done_id), 1);
    @(negedge clk);
    chk("st_no_dup", 32'(done), 0);
    $display("stall done z=%h id=%0d", z, done_id);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
